multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the MIPS-subset processor. It sequences fetch, decode, execute, memory and write-back per instruction, and adds the following:
- load/store and BNE support;
- a memory ready handshake;
- a run/pause gate;
- illegal-opcode trapping;
- a retired-instruction counter.

It sits beside the datapath and drives every mux select and write enable from its state register.

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU/mux selects
// and the controller state enum.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] R_OP = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EX_R     = 4'd3,
    WB_R     = 4'd4,
    EX_I     = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    HALT     = 4'd13,
    TRAP     = 4'd14
  } state_e;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: Moore-decoded datapath controls, memory
// ready handshake, run gate, illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int RETIRE_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opCode,
  input  logic                run,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNe,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                halted,
  output logic                trapped,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  state_e                state_r;
  state_e                next_s;
  logic                  nop_r;
  logic                  nop_set_s;
  logic                  retire_s;
  logic                  rdy_s;
  logic [RETIRE_W-1:0]   retired_r;

  assign rdy_s   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state   = state_r;
  assign retired = retired_r;

  // State, NOP marker and retired counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      nop_r     <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      nop_r   <= nop_set_s;
      if (retire_s) begin
        retired_r <= retired_r + RETIRE_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state, retire pulse and NOP marker.
  always_comb begin
    next_s    = state_r;
    retire_s  = 1'b0;
    nop_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        // An IDLE cycle entered from an illegal opcode completes that NOP.
        retire_s = nop_r;
        if (run) next_s = FETCH;
        else     next_s = IDLE;
      end
      FETCH: begin
        if (rdy_s) next_s = DECODE;
        else       next_s = FETCH;
      end
      DECODE: begin
        case (opCode)
          OP_RTYPE:      next_s = EX_R;
          OP_ADDI:       next_s = EX_I;
          OP_LW, OP_SW:  next_s = MEM_ADDR;
          OP_BEQ, OP_BNE: next_s = BRANCH;
          OP_J:          next_s = JUMP;
          OP_HALT: begin
            next_s   = HALT;
            retire_s = 1'b1;
          end
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_s = TRAP;
            end else begin
              next_s    = IDLE;
              nop_set_s = 1'b1;
            end
          end
        endcase
      end
      EX_R:     next_s = WB_R;
      EX_I:     next_s = WB_I;
      MEM_ADDR: begin
        if (opCode == OP_SW) next_s = MEM_WR;
        else                 next_s = MEM_RD;
      end
      MEM_RD: begin
        if (rdy_s) next_s = MEM_WB;
        else       next_s = MEM_RD;
      end
      MEM_WR: begin
        if (rdy_s) begin
          retire_s = 1'b1;
          if (run) next_s = FETCH;
          else     next_s = IDLE;
        end else begin
          next_s = MEM_WR;
        end
      end
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: begin
        retire_s = 1'b1;
        if (run) next_s = FETCH;
        else     next_s = IDLE;
      end
      HALT:    next_s = HALT;
      TRAP:    next_s = TRAP;
      default: next_s = IDLE;
    endcase
  end

  // Moore control decode; FETCH strobes follow the memory handshake.
  always_comb begin
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    ALUOp       = R_OP;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    halted      = 1'b0;
    trapped     = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ADD;
        IRWrite = rdy_s;
        PCWrite = rdy_s;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ALUOp   = ADD;
      end
      EX_R: begin
        ALUSrcA = 1'b1;
      end
      WB_R: begin
        ALUSrcA  = 1'b1;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      EX_I, MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ADD;
      end
      WB_I: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ADD;
        RegWrite = 1'b1;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = SUB;
        PCSource    = PCSRC_ALUOUT;
        PCWriteCond = 1'b1;
        BranchNe    = opCode[0];
      end
      JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      HALT:    halted  = 1'b1;
      TRAP:    trapped = 1'b1;
      default: halted  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one default instance and one with
// handshake off, NOP on illegal opcode and a 4-bit retired counter.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  // {mem_req,IorD,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,
  //  PCWrite,PCWriteCond,BranchNe,ALUOp,ALUSrcB,PCSource}
  localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_0_0_0_1_0_0_01_01_00;
  localparam logic [16:0] C_FWAIT  = 17'b1_0_0_0_0_0_0_0_0_0_0_01_01_00;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_0_01_11_00;
  localparam logic [16:0] C_EXR    = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [16:0] C_WBR    = 17'b0_0_0_0_0_1_1_1_0_0_0_00_00_00;
  localparam logic [16:0] C_EXI    = 17'b0_0_0_0_0_0_0_1_0_0_0_01_10_00;
  localparam logic [16:0] C_WBI    = 17'b0_0_0_0_0_1_0_1_0_0_0_01_10_00;
  localparam logic [16:0] C_MEMRD  = 17'b1_1_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_1_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MEMWR  = 17'b1_1_1_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_BNE    = 17'b0_0_0_0_0_0_0_1_0_1_1_10_00_01;
  localparam logic [16:0] C_BEQ    = 17'b0_0_0_0_0_0_0_1_0_1_0_10_00_01;
  localparam logic [16:0] C_JUMP   = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_run, a_mr;
  logic [5:0]  a_op;
  logic        a_mem_req, a_IorD, a_MemWrite, a_IRWrite, a_MemtoReg, a_RegWrite, a_RegDst;
  logic        a_ALUSrcA, a_PCWrite, a_PCWriteCond, a_BranchNe, a_halted, a_trapped;
  logic [1:0]  a_ALUOp, a_ALUSrcB, a_PCSource;
  logic [3:0]  a_state;
  logic [31:0] a_retired;
  logic [16:0] a_ctl;

  logic        b_reset, b_run, b_mr;
  logic [5:0]  b_op;
  logic        b_mem_req, b_IorD, b_MemWrite, b_IRWrite, b_MemtoReg, b_RegWrite, b_RegDst;
  logic        b_ALUSrcA, b_PCWrite, b_PCWriteCond, b_BranchNe, b_halted, b_trapped;
  logic [1:0]  b_ALUOp, b_ALUSrcB, b_PCSource;
  logic [3:0]  b_state;
  logic [3:0]  b_retired;
  logic [16:0] b_ctl;

  assign a_ctl = {a_mem_req, a_IorD, a_MemWrite, a_IRWrite, a_MemtoReg, a_RegWrite, a_RegDst,
                  a_ALUSrcA, a_PCWrite, a_PCWriteCond, a_BranchNe, a_ALUOp, a_ALUSrcB, a_PCSource};
  assign b_ctl = {b_mem_req, b_IorD, b_MemWrite, b_IRWrite, b_MemtoReg, b_RegWrite, b_RegDst,
                  b_ALUSrcA, b_PCWrite, b_PCWriteCond, b_BranchNe, b_ALUOp, b_ALUSrcB, b_PCSource};

  multicycle_ctrl u_a (
    .clk(clk), .reset(a_reset), .opCode(a_op), .run(a_run), .mem_ready(a_mr),
    .mem_req(a_mem_req), .IorD(a_IorD), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
    .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .RegDst(a_RegDst), .ALUSrcA(a_ALUSrcA),
    .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .BranchNe(a_BranchNe),
    .ALUOp(a_ALUOp), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
    .halted(a_halted), .trapped(a_trapped), .state(a_state), .retired(a_retired)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .RETIRE_W(4)) u_b (
    .clk(clk), .reset(b_reset), .opCode(b_op), .run(b_run), .mem_ready(b_mr),
    .mem_req(b_mem_req), .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .RegDst(b_RegDst), .ALUSrcA(b_ALUSrcA),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .BranchNe(b_BranchNe),
    .ALUOp(b_ALUOp), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
    .halted(b_halted), .trapped(b_trapped), .state(b_state), .retired(b_retired)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b0; a_run = 1'b0; a_mr = 1'b1; a_op = OP_RTYPE;
    b_reset = 1'b0; b_run = 1'b0; b_mr = 1'b0; b_op = 6'b010101;
    #12;
    chk("rst_state", 32'(a_state), 32'(IDLE));
    chk("rst_ctl", 32'(a_ctl), 32'(C_ZERO));
    chk("rst_retired", a_retired, 32'd0);
    chk("rst_status", 32'({a_halted, a_trapped}), 32'd0);
    a_reset = 1'b1; a_run = 1'b1;

    // R-type, zero wait states
    cyc(); chk("r_fetch_st", 32'(a_state), 32'(FETCH));
    chk("r_fetch_ctl", 32'(a_ctl), 32'(C_FETCH));
    cyc(); chk("r_decode_ctl", 32'(a_ctl), 32'(C_DECODE));
    cyc(); chk("r_exr_st", 32'(a_state), 32'(EX_R));
    chk("r_exr_ctl", 32'(a_ctl), 32'(C_EXR));
    cyc(); chk("r_wbr_ctl", 32'(a_ctl), 32'(C_WBR));
    chk("r_wbr_retired", a_retired, 32'd0);
    a_op = OP_LW;
    cyc(); chk("r_done_st", 32'(a_state), 32'(FETCH));
    chk("r_done_retired", a_retired, 32'd1);

    // LW with two wait cycles in MEM_RD: 7 cycles from FETCH
    cyc(); chk("lw_decode_st", 32'(a_state), 32'(DECODE));
    cyc(); chk("lw_addr_ctl", 32'(a_ctl), 32'(C_EXI));
    a_mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("lw_rd_st", 32'(a_state), 32'(MEM_RD));
      chk("lw_rd_ctl", 32'(a_ctl), 32'(C_MEMRD));
    end
    a_mr = 1'b1;
    cyc(); chk("lw_wb_st", 32'(a_state), 32'(MEM_WB));
    chk("lw_wb_ctl", 32'(a_ctl), 32'(C_MEMWB));
    a_op = OP_SW;
    cyc(); chk("lw_done_retired", a_retired, 32'd2);

    // SW with a wait in FETCH and one in MEM_WR
    a_mr = 1'b0; #1;
    chk("sw_fwait_ctl", 32'(a_ctl), 32'(C_FWAIT));
    cyc(); chk("sw_fwait_st", 32'(a_state), 32'(FETCH));
    a_mr = 1'b1; #1;
    chk("sw_fready_ctl", 32'(a_ctl), 32'(C_FETCH));
    cyc(); cyc(); chk("sw_addr_st", 32'(a_state), 32'(MEM_ADDR));
    a_mr = 1'b0;
    cyc(); chk("sw_wr_ctl", 32'(a_ctl), 32'(C_MEMWR));
    cyc(); chk("sw_wr_hold_st", 32'(a_state), 32'(MEM_WR));
    chk("sw_wr_hold_ctl", 32'(a_ctl), 32'(C_MEMWR));
    chk("sw_wr_hold_retired", a_retired, 32'd2);
    a_mr = 1'b1; a_op = OP_BNE;
    cyc(); chk("sw_done_st", 32'(a_state), 32'(FETCH));
    chk("sw_done_retired", a_retired, 32'd3);

    // BNE then BEQ
    cyc(); cyc(); chk("bne_st", 32'(a_state), 32'(BRANCH));
    chk("bne_ctl", 32'(a_ctl), 32'(C_BNE));
    a_op = OP_BEQ;
    cyc(); chk("bne_retired", a_retired, 32'd4);
    cyc(); cyc(); chk("beq_ctl", 32'(a_ctl), 32'(C_BEQ));
    a_op = OP_ADDI;
    cyc(); chk("beq_retired", a_retired, 32'd5);

    // ADDI
    cyc(); cyc(); chk("addi_ex_ctl", 32'(a_ctl), 32'(C_EXI));
    cyc(); chk("addi_wb_ctl", 32'(a_ctl), 32'(C_WBI));
    a_op = 6'b010101;
    cyc(); chk("addi_retired", a_retired, 32'd6);

    // Illegal opcode traps and sticks
    cyc(); cyc(); chk("trap_st", 32'(a_state), 32'(TRAP));
    chk("trap_flag", 32'(a_trapped), 32'd1);
    for (int i = 0; i < 5; i++) cyc();
    chk("trap_hold_st", 32'(a_state), 32'(TRAP));
    chk("trap_ctl", 32'(a_ctl), 32'(C_ZERO));
    chk("trap_retired", a_retired, 32'd6);
    a_reset = 1'b0; #1;
    chk("trap_rst_st", 32'(a_state), 32'(IDLE));
    chk("trap_rst_flag", 32'(a_trapped), 32'd0);
    chk("trap_rst_retired", a_retired, 32'd0);
    a_reset = 1'b1; a_op = OP_HALT;

    // HALT counts on entry and holds for 100 cycles
    cyc(); cyc(); cyc(); chk("halt_st", 32'(a_state), 32'(HALT));
    chk("halt_retired", a_retired, 32'd1);
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("halt_hold", 32'({a_state, a_halted, a_ctl}), 32'({4'(HALT), 1'b1, C_ZERO}));
    end
    #3; a_reset = 1'b0; #1;
    chk("halt_arst", 32'({a_state, a_halted, a_ctl}), 32'({4'(IDLE), 1'b0, C_ZERO}));
    chk("halt_arst_retired", a_retired, 32'd0);

    // Instance B: mem_ready held low but ignored; illegal opcode is a NOP
    b_reset = 1'b1; b_run = 1'b1;
    cyc(); chk("b_fetch_ctl", 32'(b_ctl), 32'(C_FETCH));
    cyc(); chk("b_decode_st", 32'(b_state), 32'(DECODE));
    cyc(); chk("b_nop_st", 32'(b_state), 32'(IDLE));
    chk("b_nop_ret0", 32'(b_retired), 32'd0);
    b_op = OP_J;
    cyc(); chk("b_nop_fetch", 32'(b_state), 32'(FETCH));
    chk("b_nop_ret1", 32'(b_retired), 32'd1);
    chk("b_status", 32'({b_halted, b_trapped}), 32'd0);
    exp_ret = 1;

    // 16 jumps, wrap of the 4-bit counter, run dropped during the third
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 2) b_run = 1'b0;
      cyc(); chk("j_ctl", 32'(b_ctl), 32'(C_JUMP));
      cyc();
      exp_ret = (exp_ret + 1) % 16;
      chk("j_retired", 32'(b_retired), 32'(exp_ret));
      if (k == 2) begin
        chk("j_pause_st", 32'(b_state), 32'(IDLE));
        cyc(); chk("j_pause_hold", 32'({b_state, b_retired}), 32'({4'(IDLE), 4'(exp_ret)}));
        b_run = 1'b1;
        cyc(); chk("j_resume_st", 32'(b_state), 32'(FETCH));
      end else begin
        chk("j_next_st", 32'(b_state), 32'(FETCH));
      end
    end
    chk("j_final_retired", 32'(b_retired), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
